// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation job sequencer.
// Contents: operand/word widths, job word counts, sequencer state encoding.
package rsa_pkg;

  localparam int unsigned KEY_W     = 128;
  localparam int unsigned EXP_W     = 32;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned M_WORDS   = 4;
  localparam int unsigned N_WORDS   = 4;
  localparam int unsigned JOB_WORDS = 9;

  typedef enum logic [1:0] {
    StLoad,
    StLaunch,
    StWait,
    StDrain
  } seq_state_t;

endpackage

// File: rtl/rsa_exp_sequencer_if.sv
// Job-word input stream and result-word output stream of the sequencer.
// Signals: in_valid/in_ready/in_data (job words in), out_valid/out_ready/out_data/out_last
// (result words out). The sequencer uses the slave modport, its environment the master modport.
interface rsa_exp_sequencer_if;
  import rsa_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/rsa_word_unpacker.sv
// Captures a 128-bit result and streams it out as four 32-bit words, least-significant first.
// Ports: clk, reset (sync, active-high), load (capture din and start draining), din,
// out_ready (downstream accept), out_valid, out_data, out_last (high on the 4th word).
module rsa_word_unpacker
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [KEY_W-1:0]  din,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last
);

  logic [KEY_W-1:0] result_q;
  logic [1:0]       idx_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      idx_q    <= 2'd0;
      valid_q  <= 1'b0;
    end else if (load) begin
      result_q <= din;
      idx_q    <= 2'd0;
      valid_q  <= 1'b1;
    end else if (valid_q && out_ready) begin
      // Index wraps 3 -> 0, so it is already cleared for the next result.
      idx_q <= idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    out_valid = valid_q;
    out_data  = valid_q ? result_q[{idx_q, 5'b0} +: WORD_W] : '0;
    out_last  = valid_q && (idx_q == 2'd3);
  end

endmodule

// File: rtl/rsa_exp_sequencer.sv
// Job sequencer around the modular exponentiator: collects m (4 words), n (4 words) and e
// (1 word), pulses exp_reset for one cycle to launch, waits for exp_ready, then streams c out
// as four words.
// Ports: clk, reset (sync, active-high), bus (job/result streams, slave modport),
// exp_m/exp_n/exp_e (registered operands), exp_reset, exp_c, exp_ready, busy,
// timeout (sticky abort flag, only when RSA_EXP_SEQ_TIMEOUT_EN is defined).
// Build option: RSA_EXP_SEQ_TIMEOUT_EN enables the TIMEOUT_CYCLES abort of WAIT.
module rsa_exp_sequencer
  import rsa_pkg::*;
`ifdef RSA_EXP_SEQ_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 2**20
)
`endif
(
  input  logic                 clk,
  input  logic                 reset,
  rsa_exp_sequencer_if.slave   bus,
  output logic [KEY_W-1:0]     exp_m,
  output logic [KEY_W-1:0]     exp_n,
  output logic [EXP_W-1:0]     exp_e,
  output logic                 exp_reset,
  input  logic [KEY_W-1:0]     exp_c,
  input  logic                 exp_ready,
  output logic                 busy
`ifdef RSA_EXP_SEQ_TIMEOUT_EN
  ,
  output logic                 timeout
`endif
);

  seq_state_t       state_q;
  logic [3:0]       word_cnt_q;
  logic [KEY_W-1:0] m_q;
  logic [KEY_W-1:0] n_q;
  logic [EXP_W-1:0] e_q;

  logic accept;
  logic capture;
  logic drain_done;

`ifdef RSA_EXP_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] wait_cnt_q;
  logic            timeout_q;
  logic            timeout_hit;
  assign timeout_hit = (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign timeout     = timeout_q;
`endif

  assign bus.in_ready = (state_q == StLoad) && !reset;
  assign accept       = bus.in_valid && bus.in_ready;
  // exp_ready is only looked at in WAIT; a stale level during LAUNCH is ignored.
  assign capture      = (state_q == StWait) && exp_ready;
  assign drain_done   = bus.out_valid && bus.out_ready && bus.out_last;

  assign exp_m     = m_q;
  assign exp_n     = n_q;
  assign exp_e     = e_q;
  assign exp_reset = reset || (state_q == StLaunch);
  assign busy      = (state_q != StLoad);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StLoad;
      word_cnt_q <= 4'd0;
      m_q        <= '0;
      n_q        <= '0;
      e_q        <= '0;
`ifdef RSA_EXP_SEQ_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StLoad: begin
          if (accept) begin
            if (word_cnt_q < 4'(M_WORDS)) begin
              m_q[{word_cnt_q[1:0], 5'b0} +: WORD_W] <= bus.in_data;
            end else if (word_cnt_q < 4'(M_WORDS + N_WORDS)) begin
              n_q[{word_cnt_q[1:0], 5'b0} +: WORD_W] <= bus.in_data;
            end else begin
              e_q <= bus.in_data;
            end
            if (word_cnt_q == 4'(JOB_WORDS - 1)) begin
              word_cnt_q <= 4'd0;
              state_q    <= StLaunch;
`ifdef RSA_EXP_SEQ_TIMEOUT_EN
              wait_cnt_q <= '0;
              timeout_q  <= 1'b0;
`endif
            end else begin
              word_cnt_q <= word_cnt_q + 4'd1;
            end
          end
        end
        StLaunch: begin
          state_q <= StWait;
        end
        StWait: begin
          if (exp_ready) begin
            state_q <= StDrain;
`ifdef RSA_EXP_SEQ_TIMEOUT_EN
          end else if (timeout_hit) begin
            timeout_q <= 1'b1;
            state_q   <= StLoad;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
          end
        end
        StDrain: begin
          if (drain_done) begin
            state_q <= StLoad;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  rsa_word_unpacker u_unpacker (
    .clk       (clk),
    .reset     (reset),
    .load      (capture),
    .din       (exp_c),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .out_last  (bus.out_last)
  );

endmodule

// File: tb/tb_rsa_exp_sequencer.sv
// Self-checking bench for rsa_exp_sequencer: behavioural exponentiator model, directed and
// randomized jobs, flow-control stalls, stale-ready, mid-operation reset and (when
// RSA_EXP_SEQ_TIMEOUT_EN is defined) the WAIT timeout.
module tb_rsa_exp_sequencer;
  import rsa_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rsa_exp_sequencer_if bus ();

  logic [127:0] exp_m, exp_n;
  logic [31:0]  exp_e;
  logic         exp_reset;
  logic [127:0] exp_c = '0;
  logic         exp_ready = 1'b0;
  logic         busy;

  int checks = 0;
  int errors = 0;

`ifdef RSA_EXP_SEQ_TIMEOUT_EN
  logic timeout;
  rsa_exp_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .exp_m     (exp_m),
    .exp_n     (exp_n),
    .exp_e     (exp_e),
    .exp_reset (exp_reset),
    .exp_c     (exp_c),
    .exp_ready (exp_ready),
    .busy      (busy),
    .timeout   (timeout)
  );
`else
  rsa_exp_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .exp_m     (exp_m),
    .exp_n     (exp_n),
    .exp_e     (exp_e),
    .exp_reset (exp_reset),
    .exp_c     (exp_c),
    .exp_ready (exp_ready),
    .busy      (busy)
  );
`endif

  // Reference arithmetic: m^e mod n by square-and-multiply.
  function automatic logic [127:0] modexp(input logic [127:0] m, input logic [127:0] n,
                                          input logic [31:0] e);
    logic [255:0] r, b, nn;
    if (n == 0) return '0;
    nn = {128'd0, n};
    r  = 256'd1 % nn;
    b  = {128'd0, m} % nn;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[127:0];
  endfunction

  // Exponentiator model: ready drops on the reset edge (e = 0 answers at once), rises after
  // lat_cfg cycles, and otherwise stays high until the next reset.
  int lat_cfg     = 3;
  bit never_ready = 1'b0;
  int mdl_cnt     = 0;

  always @(posedge clk) begin
    if (exp_reset) begin
      if (exp_e == 0 && !never_ready) begin
        exp_ready <= 1'b1;
        exp_c     <= modexp(exp_m, exp_n, exp_e);
        mdl_cnt   <= 0;
      end else begin
        exp_ready <= 1'b0;
        exp_c     <= {4{32'hDEADBEEF}};
        mdl_cnt   <= never_ready ? 0 : lat_cfg;
      end
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        exp_ready <= 1'b1;
        exp_c     <= modexp(exp_m, exp_n, exp_e);
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("in_ready_bound", bus.in_ready, 1'b1);
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge of the LAUNCH cycle when nwords == 9.
  task automatic load_job(input logic [127:0] m, input logic [127:0] n, input logic [31:0] e,
                          input int lat, input bit gaps, input int nwords);
    logic [31:0] w [9];
    lat_cfg = lat;
    for (int i = 0; i < 4; i++) begin
      w[i]     = m[i*32 +: 32];
      w[i + 4] = n[i*32 +: 32];
    end
    w[8] = e;
    for (int i = 0; i < nwords; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      send_word(w[i]);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_job(input logic [127:0] m, input logic [127:0] n, input logic [31:0] e,
                            input int lat, input int stall);
    logic [127:0] c_ref;
    int t;
    c_ref = modexp(m, n, e);
    chk("launch_exp_reset", exp_reset, 1'b1);
    chk("launch_m", exp_m, m);
    chk("launch_n", exp_n, n);
    chk("launch_e", exp_e, e);
    t = 0;
    while (!bus.out_valid && t < lat + 20) begin
      @(negedge clk);
      t++;
    end
    chk("result_latency", t, (e == 0) ? 2 : lat + 2);
    chk("wait_n_held", exp_n, n);
    for (int k = 0; k < 4; k++) begin
      if (k == stall) begin
        bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", bus.out_valid, 1'b1);
          chk("stall_data", bus.out_data, c_ref[k*32 +: 32]);
          chk("stall_last", bus.out_last, k == 3);
        end
        bus.out_ready = 1'b1;
      end
      chk("out_valid", bus.out_valid, 1'b1);
      chk("out_data", bus.out_data, c_ref[k*32 +: 32]);
      chk("out_last", bus.out_last, k == 3);
      @(negedge clk);
    end
    chk("post_in_ready", bus.in_ready, 1'b1);
    chk("post_out_valid", bus.out_valid, 1'b0);
    chk("post_busy", busy, 1'b0);
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    #1;
    chk("rst_exp_reset_now", exp_reset, 1'b1);
    chk("rst_in_ready_now", bus.in_ready, 1'b0);
    repeat (ncyc) begin
      @(negedge clk);
      chk("rst_exp_reset", exp_reset, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("rst_release_in_ready", bus.in_ready, 1'b1);
    chk("rst_release_exp_reset", exp_reset, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] m, n;
    logic [31:0]  e;
    int lat, wc;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 1'b0);
    chk("reset_exp_reset", exp_reset, 1'b1);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_out_last", bus.out_last, 1'b0);
    chk("reset_out_data", bus.out_data, 32'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_exp_m", exp_m, 128'd0);
    chk("reset_exp_n", exp_n, 128'd0);
    chk("reset_exp_e", exp_e, 32'd0);
`ifdef RSA_EXP_SEQ_TIMEOUT_EN
    chk("reset_timeout", timeout, 1'b0);
`endif
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1'b1);

    // Basic job: 5^3 mod 14 = 13.
    load_job(128'd5, 128'd14, 32'd3, 3, 1'b0, 9);
    finish_job(128'd5, 128'd14, 32'd3, 3, -1);

    // e = 0: result 1, WAIT lasts a single cycle.
    load_job(128'h1234, 128'd97, 32'd0, 3, 1'b0, 9);
    finish_job(128'h1234, 128'd97, 32'd0, 3, -1);

    // Flow control: input gaps plus a 5-cycle stall on word 2.
    m = {$urandom, $urandom, $urandom, $urandom};
    n = {1'b1, 95'(0), $urandom} | 128'd1;
    e = $urandom;
    load_job(m, n, e, 4, 1'b1, 9);
    finish_job(m, n, e, 4, 2);

    // Stale ready: previous job left exp_ready high; capture must wait for the new result.
    chk("stale_ready_present", exp_ready, 1'b1);
    load_job(128'd7, 128'd11, 32'd5, 5, 1'b0, 9);
    finish_job(128'd7, 128'd11, 32'd5, 5, -1);

    // Reset during WAIT.
    load_job(128'd3, 128'd1000, 32'd77, 40, 1'b0, 9);
    repeat (3) @(negedge clk);
    chk("wait_busy", busy, 1'b1);
    do_reset(3);
    load_job(128'd9, 128'd101, 32'd13, 2, 1'b0, 9);
    finish_job(128'd9, 128'd101, 32'd13, 2, -1);

    // Reset during LOAD after five words.
    load_job(128'hFFFF_0000_1111_2222, 128'd12345, 32'd4, 2, 1'b0, 5);
    do_reset(2);
    chk("partial_m_cleared", exp_m, 128'd0);
    chk("partial_n_cleared", exp_n, 128'd0);
    load_job(128'd2, 128'd1_000_003, 32'd20, 3, 1'b0, 9);
    finish_job(128'd2, 128'd1_000_003, 32'd20, 3, -1);

    // Randomized jobs.
    for (int j = 0; j < 3; j++) begin
      m   = {$urandom, $urandom, $urandom, $urandom};
      n   = {$urandom, $urandom, $urandom, $urandom} | {1'b1, 127'd1};
      e   = $urandom;
      lat = $urandom_range(1, 6);
      load_job(m, n, e, lat, 1'b1, 9);
      finish_job(m, n, e, lat, $urandom_range(0, 3));
    end

`ifdef RSA_EXP_SEQ_TIMEOUT_EN
    // Timeout: model never answers; 16 WAIT cycles then back to LOAD without output.
    never_ready = 1'b1;
    load_job(128'd5, 128'd14, 32'd3, 3, 1'b0, 9);
    wc = 0;
    do begin
      @(negedge clk);
      if (busy) begin
        wc++;
        chk("timeout_no_out_valid", bus.out_valid, 1'b0);
      end
    end while (busy && wc < 100);
    chk("timeout_wait_cycles", wc, 16);
    chk("timeout_flag", timeout, 1'b1);
    chk("timeout_in_ready", bus.in_ready, 1'b1);
    chk("timeout_out_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    chk("timeout_sticky", timeout, 1'b1);
    never_ready = 1'b0;
    load_job(128'd6, 128'd35, 32'd7, 2, 1'b0, 9);
    finish_job(128'd6, 128'd35, 32'd7, 2, -1);
    chk("timeout_cleared", timeout, 1'b0);
`else
    wc = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_exp_sequencer.md
# rsa_exp_sequencer

Job sequencer that sits directly upstream and downstream of the modular exponentiator (128-bit m/n, 32-bit e, 128-bit c, ready).
- Collects one job as a stream of 32-bit words: message, modulus, then exponent.
- Launches the exponentiator with a one-cycle reset pulse and holds its operands stable while it runs.
- Captures c when ready rises, then streams c out as four 32-bit words under valid/ready flow control.

## Interface
- TIMEOUT_CYCLES, 2**20, maximum WAIT cycles before abort; used only when the timeout feature is compiled in.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; returns the block to LOAD.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block accepts a word.
- in_data  in  32  job word.
- exp_m  out  128  exponentiator message operand, registered.
- exp_n  out  128  exponentiator modulus operand, registered.
- exp_e  out  32  exponentiator exponent operand, registered.
- exp_reset  out  1  exponentiator reset; equals reset OR (state==LAUNCH).
- exp_c  in  128  exponentiator result.
- exp_ready  in  1  exponentiator done, level.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts a word.
- out_data  out  32  result word.
- out_last  out  1  marks the 4th result word.
- busy  out  1  high in LAUNCH, WAIT and DRAIN.
- timeout  out  1  sticky abort flag; present only with the macro.

## Operation
- States: LOAD, LAUNCH, WAIT, DRAIN; reset forces LOAD with word counter = 0.
- LOAD
  - in_ready = 1 except while reset is high.
  - A word transfers when in_valid & in_ready.
  - Word index 0–3 → exp_m[32k+31:32k], least-significant word first.
  - Word index 4–7 → exp_n, same ordering.
  - Word index 8 → exp_e.
  - Acceptance of index 8 → LAUNCH.
- LAUNCH
  - Lasts exactly one cycle.
  - exp_reset = 1; the exponentiator samples m/e/n on this edge.
  - Next state: WAIT.
- WAIT
  - exp_ready is sampled only in WAIT; it is never sampled in LAUNCH, which discards any stale ready left by a previous job.
  - On exp_ready = 1: capture exp_c into the result register, clear the drain index, go to DRAIN.
- DRAIN
  - out_valid = 1; out_data = result[32k+31:32k] for drain index k = 0..3.
  - out_last = (k == 3).
  - The index advances only on out_valid & out_ready.
  - Transfer of k = 3 → LOAD.
- exp_m, exp_n, exp_e change only in LOAD. exp_n is held constant through WAIT because the exponentiator uses n every cycle.
- Reset mid-operation, any state:
  - Next cycle is LOAD, counters = 0, out_valid = 0.
  - exp_reset is high for the whole reset period.
  - Partially loaded words are discarded.
- Reset values:
  - in_ready 0 during reset, 1 after.
  - out_valid 0, out_last 0, out_data 0, busy 0, timeout 0.
  - exp_m, exp_n, exp_e 0.
  - exp_reset 1 during reset.

## Timing
- Load: 9 cycles minimum; in_valid gaps stall the counter without loss.
- Index-8 acceptance edge → LAUNCH on the next cycle → WAIT on the cycle after.
- exp_ready sampled high in WAIT → out_valid on the next cycle.
- Drain: 4 cycles minimum. While out_ready = 0, out_data and out_last hold stable.
- Back-to-back jobs: in_ready returns the cycle after the final drain transfer.
- With e = 0 the exponentiator signals ready one cycle after its reset, so WAIT lasts 1 cycle.

## Configuration
- RSA_EXP_SEQ_TIMEOUT_EN defined:
  - A WAIT cycle counter starts at 0 on LAUNCH.
  - When the count reaches TIMEOUT_CYCLES without exp_ready: set timeout = 1, skip DRAIN, go to LOAD.
  - timeout clears on the next LAUNCH or on reset.
  - If exp_ready and the timeout condition occur in the same cycle, exp_ready wins.
- Not defined: no counter and no timeout port; WAIT lasts indefinitely.

## Structure
- Package rsa_pkg:
  - KEY_W = 128, EXP_W = 32, WORD_W = 32.
  - M_WORDS = 4, N_WORDS = 4, JOB_WORDS = 9.
  - State enum seq_state_t.
- One sub-module: rsa_word_unpacker — 128-bit capture register plus 2-bit drain index, producing out_valid / out_data / out_last from a load strobe and out_ready.

## Test plan
- Basic job: load m = 5, n = 14, e = 3 with a behavioural exponentiator model → out words 0x0000000D, 0, 0, 0 in that order, out_last high only on the 4th, then in_ready = 1.
- e = 0: load m = 0x1234, n = 97, e = 0 → WAIT lasts 1 cycle; out words 0x00000001, 0, 0, 0.
- Flow control: random in_valid gaps and out_ready held low for 5 cycles on word 2 → exp_m/exp_n/exp_e are correct; word 2 is held stable; no word is dropped or duplicated.
- Stale ready: previous job leaves exp_ready = 1 and the model drops it one cycle after exp_reset → no early capture; the correct new c is output.
- Reset during WAIT and during word 5 of LOAD → exp_reset high throughout; out_valid = 0; a fresh 9-word job then completes correctly.
- Macro defined, TIMEOUT_CYCLES = 16, model never asserts ready → timeout = 1 after 16 WAIT cycles; no out_valid; LOAD resumes; the next LAUNCH clears timeout.
